mem_bus_arbiter: RTL

// - Shares one native memory port (valid/ready/addr/wdata/wstrb/rdata) between two masters:
//   M0 = picorv32 core, M1 = secondary master (DMA/debug loader).
// - Sits between the masters and the on-chip memory/LED decode block; the slave is unchanged.
// - Round-robin arbitration, grant held until the slave completes.
// - A bus watchdog completes hung transfers with an error word.

---
 rtl/mem_bus_pkg.sv | 18 +
 rtl/mem_bus_rr_pick.sv | 22 ++
 rtl/mem_bus_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_bus_pkg;

  // Default bus geometry of the native picorv32 memory port
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  // Read data handed back to a master whose transfer was killed by the watchdog
  localparam logic [31:0] MEM_ERR_RDATA = 32'hDEAD_BEEF;

  // Arbiter sequencing: pick a master, run one slave transfer, then one dead cycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_bus_rr_pick.sv
// Two-way round-robin selector: a lone requester always wins, and on a tie
// the master that was not granted last time gets the bus.
module mem_bus_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner,
  output logic       any
);

  // Pure combinational pick; winner is meaningless when any is low
  always_comb begin
    any    = |req;
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one native memory port between the picorv32 core (M0) and a
// secondary master (M1). One transfer at a time, round-robin on ties, the
// grant is held until the slave completes, and a watchdog forces completion
// of transfers the slave never answers.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int                ADDR_W    = MEM_ADDR_W,
  parameter int                DATA_W    = MEM_DATA_W,
  parameter int                TIMEOUT   = 255,
  parameter logic [DATA_W-1:0] ERR_RDATA = MEM_ERR_RDATA,
  parameter bit                M0_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            m_valid,
  input  logic [2*ADDR_W-1:0]   m_addr,
  input  logic [2*DATA_W-1:0]   m_wdata,
  input  logic [2*DATA_W/8-1:0] m_wstrb,
  output logic [1:0]            m_ready,
  output logic [DATA_W-1:0]     m_rdata,
  output logic                  s_valid,
  output logic [ADDR_W-1:0]     s_addr,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_ready,
  input  logic [DATA_W-1:0]     s_rdata,
  output logic                  bus_err,
  output logic                  err_master
);

  localparam int STRB_W = DATA_W / 8;

  // Watchdog is kept at least one bit wide so TIMEOUT=0 still elaborates
  localparam int                WD_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0]   WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
  localparam logic [WD_W-1:0]   WD_MAX  = '1;

  // The preferred master wins the first tie when last_grant points at the other one
  localparam logic LAST_GRANT_RST = M0_FIRST ? 1'b1 : 1'b0;

  arb_state_t          state;
  logic                grant;
  logic                last_grant;
  logic [WD_W-1:0]     wdog;

  logic                pick_winner;
  logic                pick_any;

  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;
  logic [STRB_W-1:0]   win_wstrb;

  logic                req_held;
  logic                wd_expire;
  logic                done_ok;
  logic                done_to;
  logic                abort;

  mem_bus_rr_pick u_pick (
    .req        (m_valid),
    .last_grant (last_grant),
    .winner     (pick_winner),
    .any        (pick_any)
  );

  // Route the winning master's request fields toward the slave registers
  always_comb begin
    win_addr  = m_addr[0 +: ADDR_W];
    win_wdata = m_wdata[0 +: DATA_W];
    win_wstrb = m_wstrb[0 +: STRB_W];
    if (pick_winner) begin
      win_addr  = m_addr[ADDR_W +: ADDR_W];
      win_wdata = m_wdata[DATA_W +: DATA_W];
      win_wstrb = m_wstrb[STRB_W +: STRB_W];
    end
  end

  // Classify how the current BUSY cycle ends: slave answer, watchdog, or master abort.
  // A slave answer on the watchdog's last cycle wins over the timeout.
  always_comb begin
    req_held  = m_valid[grant];
    wd_expire = (TIMEOUT != 0) && (wdog == WD_LAST);
    done_ok   = (state == BUSY) && req_held && s_ready;
    done_to   = (state == BUSY) && req_held && !s_ready && wd_expire;
    abort     = (state == BUSY) && !req_held;
  end

  // Completion pulse and read data go back to the granted master in the same cycle
  always_comb begin
    m_ready = 2'b00;
    m_rdata = s_rdata;
    if (done_ok || done_to) begin
      m_ready[grant] = 1'b1;
    end
    if (done_to) begin
      m_rdata = ERR_RDATA;
    end
  end

  // Arbitration FSM with request capture, watchdog and sticky error reporting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= LAST_GRANT_RST;
      wdog       <= '0;
      s_valid    <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= '0;
      s_wstrb    <= '0;
      bus_err    <= 1'b0;
      err_master <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant      <= pick_winner;
            last_grant <= pick_winner;
            s_addr     <= win_addr;
            s_wdata    <= win_wdata;
            s_wstrb    <= win_wstrb;
            s_valid    <= 1'b1;
            wdog       <= '0;
            state      <= BUSY;
          end
        end

        BUSY: begin
          if (done_ok || done_to || abort) begin
            s_valid <= 1'b0;
            state   <= DONE;
            if (done_to) begin
              bus_err    <= 1'b1;
              err_master <= grant;
            end
          end else if (wdog != WD_MAX) begin
            wdog <= wdog + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          s_valid <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
